// File: rtl/cdc_ctrl_pkg.sv
// Shared definitions for the source-side CDC bus controllers:
// FSM state encodings and default bus geometry.
package cdc_ctrl_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_TIMEOUT    = 255;

  // Transfer FSM. Encodings are fixed so they line up with debug tooling.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    REQ     = 2'b10,
    RELEASE = 2'b11
  } cdc_state_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
// Used to bring the destination acknowledge into the source clock domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_bus_tx_arbiter.sv
// Source-domain controller sharing one enable-qualified CDC bus between two
// requesters. Round-robin grant, one settle cycle with the data held and the
// enable low, then a 4-phase level handshake against a synchronized ack.
// The data register only loads in IDLE, so the bus cannot change while
// bus_EN is high or in the cycle it rises.
module cdc_bus_tx_arbiter
  import cdc_ctrl_pkg::*;
#(
  parameter int Width      = DEF_WIDTH,
  parameter int NUM_Stages = DEF_NUM_STAGES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req0_valid,
  input  logic [Width-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [Width-1:0] req1_data,
  output logic             req1_ready,
  output logic [Width-1:0] Async_bus,
  output logic             bus_EN,
  input  logic             ack_async,
  output logic             done,
  output logic             timeout_err,
  output logic             grant_id
);

  // Counter is cleared on every REQ entry, so it only has to reach TIMEOUT-1.
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  cdc_state_t       state_q, state_d;
  logic [Width-1:0] bus_q, bus_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic             gid_q, gid_d;
  logic             rr_q, rr_d;       // round-robin pointer: preferred requester
  logic             abort_q, abort_d; // current transfer ended by timeout
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ack_s;
  logic any_vld;
  logic win;
  logic grant;

  bit_sync #(.STAGES(NUM_Stages)) u_ack_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .din   (ack_async),
    .dout  (ack_s)
  );

  // Arbitration: a lone valid wins, a tie goes to the RR pointer.
  always_comb begin
    any_vld    = req0_valid | req1_valid;
    win        = (req0_valid & req1_valid) ? rr_q : req1_valid;
    grant      = (state_q == IDLE) & any_vld;
    req0_ready = grant & ~win;
    req1_ready = grant &  win;
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    en_d    = en_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = LOAD;
          bus_d   = win ? req1_data : req0_data;
          gid_d   = win;
          rr_d    = ~win;
        end
      end
      LOAD: begin
        // Data has had a full cycle to settle; now qualify it.
        state_d = REQ;
        en_d    = 1'b1;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
      REQ: begin
        if (ack_s) begin
          state_d = RELEASE;
          en_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
          en_d    = 1'b0;
          terr_d  = 1'b1;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Wait for the destination to drop ack before the bus is reusable.
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = ~abort_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops bus_EN without a clock.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bus_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      gid_q   <= 1'b0;
      rr_q    <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Async_bus   = bus_q;
  assign bus_EN      = en_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// Bench for cdc_bus_tx_arbiter: arbitration table plus hand-written
// sequences for latency, timeout, stale ack and asynchronous reset.
module tb_cdc_bus_tx_arbiter;

  localparam int W  = 8;
  localparam int NS = 2;
  localparam int TO = 8;

  logic         CLK_tb = 1'b0;
  logic         Reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic [W-1:0] Async_bus;
  logic         bus_EN;
  logic         ack_async;
  logic         done, timeout_err, grant_id;

  // Destination model: 0 = ack follows bus_EN (first sampled at the 3rd edge),
  // 1 = ack forced low, 2 = ack forced high.
  int           ack_mode;
  logic [1:0]   ack_pipe;

  cdc_bus_tx_arbiter #(.Width(W), .NUM_Stages(NS), .TIMEOUT(TO)) dut (
    .CLK         (CLK_tb),
    .Reset       (Reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .Async_bus   (Async_bus),
    .bus_EN      (bus_EN),
    .ack_async   (ack_async),
    .done        (done),
    .timeout_err (timeout_err),
    .grant_id    (grant_id)
  );

  always #5 CLK_tb = ~CLK_tb;

  always @(posedge CLK_tb or posedge Reset) begin
    if (Reset) ack_pipe <= '0;
    else       ack_pipe <= {ack_pipe[0], bus_EN};
  end

  assign ack_async = (ack_mode == 2) ? 1'b1 : (ack_mode == 1) ? 1'b0 : ack_pipe[1];

  typedef struct {
    logic         r0v;
    logic [W-1:0] r0d;
    logic         r1v;
    logic [W-1:0] r1d;
    logic         exp_gid;
    logic [W-1:0] exp_bus;
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    req0_valid = v.r0v; req0_data = v.r0d;
    req1_valid = v.r1v; req1_data = v.r1d;
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req0_ready | req1_ready) begin seen = 1'b1; break; end
      @(negedge CLK_tb);
    end
  endtask

  task automatic wait_en(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus_EN) begin seen = 1'b1; break; end
      @(negedge CLK_tb);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge CLK_tb);
    end
  endtask

  // Observe one transfer; k=0 is the negedge right after the accept edge.
  task automatic observe(input int cycles, input logic [W-1:0] exp_bus, input int drop_k,
                         output int en_cnt, output int first_en_k, output int done_k,
                         output int done_cnt, output bit stable);
    en_cnt = 0; first_en_k = -1; done_k = -1; done_cnt = 0; stable = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      if (bus_EN) begin en_cnt++; if (first_en_k < 0) first_en_k = k; end
      if (done)   begin done_cnt++; if (done_k < 0) done_k = k; end
      if (done_k < 0 && Async_bus !== exp_bus) stable = 1'b0;
      if (k == drop_k) ack_mode = 1;
      @(negedge CLK_tb);
    end
  endtask

  // Present one word on a requester from IDLE and step to the LOAD cycle.
  task automatic start_single(input bit which, input logic [W-1:0] d, input string name);
    if (which) begin req1_valid = 1'b1; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_data = d; end
    #1;
    chk({name, "_ready"}, {req0_ready, req1_ready}, which ? 2'b01 : 2'b10);
    @(posedge CLK_tb);
    @(negedge CLK_tb);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int en_cnt, first_en_k, done_k, done_cnt;
  bit stable, seen;

  initial begin
    Reset = 1'b1; ack_mode = 0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 8'hC3};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h5A};
    vecs[7] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 8'h02};

    // Reset state
    @(negedge CLK_tb); @(negedge CLK_tb);
    chk("rst_bus",   Async_bus,   8'h00);
    chk("rst_en",    bus_EN,      1'b0);
    chk("rst_done",  done,        1'b0);
    chk("rst_terr",  timeout_err, 1'b0);
    chk("rst_gid",   grant_id,    1'b0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    Reset = 1'b0;
    @(negedge CLK_tb);

    // Single request, ideal ack: 1 LOAD + 5 REQ + 5 RELEASE cycles
    start_single(1'b0, 8'hA5, "single");
    observe(20, 8'hA5, -1, en_cnt, first_en_k, done_k, done_cnt, stable);
    chk("single_en_rise", first_en_k, 1);
    chk("single_en_len",  en_cnt,     5);
    chk("single_done_k",  done_k,     11);
    chk("single_done_n",  done_cnt,   1);
    chk("single_stable",  stable,     1'b1);

    // Arbitration table, starting from a fresh RR pointer
    Reset = 1'b1; @(negedge CLK_tb); Reset = 1'b0; @(negedge CLK_tb);
    apply(vecs[0]);
    for (int i = 0; i < 8; i++) begin
      vec_t nxt;
      wait_ready(seen);
      chk($sformatf("row%0d_rdy_seen", i), seen, 1'b1);
      chk($sformatf("row%0d_ready", i), {req0_ready, req1_ready},
          vecs[i].exp_gid ? 2'b01 : 2'b10);
      @(posedge CLK_tb); @(negedge CLK_tb);
      chk($sformatf("row%0d_load", i), {grant_id, Async_bus, bus_EN},
          {vecs[i].exp_gid, vecs[i].exp_bus, 1'b0});
      nxt = (i < 7) ? vecs[i+1] : '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
      apply(nxt);
      wait_en(seen);
      chk($sformatf("row%0d_en_seen", i), seen, 1'b1);
      chk($sformatf("row%0d_busy", i), {req0_ready, req1_ready}, 2'b00);
      wait_done(seen);
      chk($sformatf("row%0d_done_seen", i), seen, 1'b1);
      chk($sformatf("row%0d_final", i), {grant_id, Async_bus},
          {vecs[i].exp_gid, vecs[i].exp_bus});
    end
    @(negedge CLK_tb);

    // Timeout: ack never comes, bus_EN high exactly TO cycles, no done
    ack_mode = 1;
    start_single(1'b0, 8'h77, "tmo");
    observe(20, 8'h77, -1, en_cnt, first_en_k, done_k, done_cnt, stable);
    chk("tmo_en_rise", first_en_k,  1);
    chk("tmo_en_len",  en_cnt,      TO);
    chk("tmo_done_n",  done_cnt,    0);
    chk("tmo_terr",    timeout_err, 1'b1);
    chk("tmo_stable",  stable,      1'b1);

    // Normal transfer after the abort; error stays sticky
    ack_mode = 0;
    start_single(1'b1, 8'h99, "post_tmo");
    observe(20, 8'h99, -1, en_cnt, first_en_k, done_k, done_cnt, stable);
    chk("post_tmo_done_k", done_k,      11);
    chk("post_tmo_gid",    grant_id,    1'b1);
    chk("post_tmo_terr",   timeout_err, 1'b1);

    // Stale ack: REQ lasts one cycle, RELEASE waits for ack low
    ack_mode = 2;
    repeat (4) @(negedge CLK_tb);
    start_single(1'b0, 8'h3C, "stale");
    observe(20, 8'h3C, 6, en_cnt, first_en_k, done_k, done_cnt, stable);
    chk("stale_en_len", en_cnt,   1);
    chk("stale_done_k", done_k,   6 + NS + 1);
    chk("stale_done_n", done_cnt, 1);
    ack_mode = 0;

    // Reset in the middle of REQ clears everything without a clock edge
    ack_mode = 1;
    start_single(1'b1, 8'hE7, "mid");
    @(negedge CLK_tb);
    chk("mid_pre_en",   bus_EN,      1'b1);
    chk("mid_pre_terr", timeout_err, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_en",   bus_EN,      1'b0);
    chk("mid_rst_bus",  Async_bus,   8'h00);
    chk("mid_rst_done", done,        1'b0);
    chk("mid_rst_terr", timeout_err, 1'b0);
    chk("mid_rst_gid",  grant_id,    1'b0);
    @(negedge CLK_tb);
    Reset = 1'b0; ack_mode = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_rr_reset", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge CLK_tb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdc_bus_tx_arbiter.md
Name: cdc_bus_tx_arbiter

Overview:
- Source-domain controller that shares one enable-qualified CDC bus between two requesters.
- Round-robin arbitration between requesters; granted word is held stable on the bus, then qualified with a level bus_EN.
- Full 4-phase handshake against a destination acknowledge, with an internal multi-flop synchronizer on that acknowledge.
- Drives the source side of the team's bus-enable data synchronizer and guarantees it is never presented changing data.

Parameters:
- Width, 8, data bus width in bits.
- NUM_Stages, 2, flop stages in the acknowledge synchronizer (legal range 2..4).
- TIMEOUT, 255, max CLK cycles in REQ waiting for ack before abort (legal range 1..65535).

Ports:
- CLK  input  1  source-domain clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  Width  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  Width  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- Async_bus  output  Width  registered data to the synchronizer.
- bus_EN  output  1  registered level enable to the synchronizer.
- ack_async  input  1  destination acknowledge level, asynchronous to CLK.
- done  output  1  one-cycle pulse: transfer completed.
- timeout_err  output  1  sticky: a transfer was aborted by timeout.
- grant_id  output  1  requester owning the current/last transfer.

Behaviour:
- Reset (asynchronous, active-high), all immediately 0:
  - Async_bus, bus_EN, done, timeout_err, grant_id.
  - Synchronizer flops, timeout counter, RR pointer (points to requester 0).
  - State returns to IDLE.
- Reset mid-transfer aborts the transfer; bus_EN falls asynchronously.
- Outputs: all registered except reqN_ready.
  - reqN_ready is combinational and high only in IDLE, for the granted requester whose valid is high.
  - A word transfers on the CLK edge where valid and ready are both high.
- Arbitration (IDLE only):
  - If one valid is high, that requester wins.
  - If both are high, the RR pointer wins.
  - On each grant, the pointer moves to the other requester.
  - Requesters must hold valid/data stable until ready.
- ack_s is ack_async after NUM_Stages flops.
- FSM states:
  - IDLE: on grant -> LOAD. Async_bus <= granted data; grant_id <= winner.
  - LOAD: one cycle, data settles, bus_EN stays 0. -> REQ; bus_EN <= 1; counter cleared.
  - REQ: bus_EN held 1, Async_bus held.
    - If ack_s == 1 -> RELEASE; bus_EN <= 0.
    - Else if counter == TIMEOUT-1 -> RELEASE; bus_EN <= 0; timeout_err <= 1.
    - Else counter increments.
  - RELEASE: bus_EN 0, Async_bus held.
    - If ack_s == 0 -> IDLE; done <= 1 for one cycle, but not after a timeout abort.
- Minimum transfer with ideal ack, where ack follows bus_EN after d cycles: accept edge, then 1 LOAD cycle, then REQ for d+NUM_Stages cycles, then RELEASE for d+NUM_Stages cycles.
- Next grant can occur in the cycle done is high (state IDLE).
- Counter width is clog2(TIMEOUT+1); it never wraps because it is cleared on REQ entry.
- ack_s already 1 on REQ entry (stale ack): exits REQ next edge; RELEASE then waits for ack low.
- Async_bus never changes while bus_EN == 1, nor in the cycle bus_EN rises.
- timeout_err clears only on Reset.
- Valid with no grant (FSM busy): ready stays 0; no data loss.

Decomposition:
- Shared package cdc_ctrl_pkg:
  - FSM state encodings IDLE=2'b00, LOAD=2'b01, REQ=2'b10, RELEASE=2'b11.
  - Default Width/NUM_Stages constants.
- One sub-module, bit_sync: NUM_Stages flop chain, async active-high reset, 1-bit in/out. Used for ack_s.

Test Plan:
- Reset: Reset high mid-REQ with bus_EN=1 -> bus_EN, Async_bus, done, timeout_err, grant_id all 0 immediately, without a CLK edge.
- Single request: req0_valid=1, data 8'hA5; ack mirrors bus_EN after 3 cycles.
  - req0_ready high 1 cycle.
  - Async_bus=A5 one cycle before bus_EN rises, and stable until IDLE.
  - done pulses once.
  - Total 1+(3+2)+(3+2) cycles after accept.
- Contention: both valid continuously, data0=8'h11, data1=8'h22 -> grants alternate 0,1,0,1; grant_id and Async_bus sequence 11,22,11,22.
- Timeout: TIMEOUT=8, ack held 0 -> bus_EN high exactly 8 cycles then falls; timeout_err=1 sticky; no done; next request proceeds normally.
- Stale ack: ack_async=1 before a request -> REQ lasts 1 cycle; RELEASE waits until ack low for NUM_Stages cycles; then done=1.
- Busy backpressure: req1_valid rises during REQ of requester 0 -> req1_ready stays 0 until IDLE, then accepted with correct data.
